// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared definitions for the 4-digit multiplexed 7-segment driver.
//   Holds the active-low segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit),
//   the "all anodes off" pattern and the shadow register bundle that is
//   latched once per frame.
//   No ports (package).
// -----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_B    = 7'h03;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_F    = 7'h0E;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Anodes are active-low; all ones means no digit is driven
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Snapshot of the inputs taken at each frame boundary
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        hex_mode;
    logic        blank_lz;
  } shadow_t;

  localparam shadow_t SHADOW_RESET = '0;

  // Returns 1 when digit k must be blanked as a leading zero: blanking is
  // enabled, k is not the rightmost digit, and every nibble from digit 3
  // down to digit k is zero.
  function automatic logic lz_blank(input logic [15:0] value,
                                    input logic [1:0]  k,
                                    input logic        enable);
    logic r;
    r = 1'b0;
    if (enable) begin
      case (k)
        2'd3:    r = (value[15:12] == 4'h0);
        2'd2:    r = (value[15:8]  == 8'h00);
        2'd1:    r = (value[15:4]  == 12'h000);
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational nibble to active-low 7-segment pattern decoder.
//   Ports:
//     i_nibble    in  4  digit value 0..15
//     i_hex_mode  in  1  1: 10..15 show A,b,C,d,E,F; 0: 10..15 show a dash
//     o_seg       out 7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = i_hex_mode ? SEG_A : SEG_DASH;
      4'hB: o_seg = i_hex_mode ? SEG_B : SEG_DASH;
      4'hC: o_seg = i_hex_mode ? SEG_C : SEG_DASH;
      4'hD: o_seg = i_hex_mode ? SEG_D : SEG_DASH;
      4'hE: o_seg = i_hex_mode ? SEG_E : SEG_DASH;
      4'hF: o_seg = i_hex_mode ? SEG_F : SEG_DASH;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Multiplexed 4-digit 7-segment display driver. One digit is driven per
//   refresh slot of REFRESH_DIV clocks; the first BLANK_CYCLES clocks of each
//   slot turn every anode off so the previous digit's pattern cannot ghost
//   onto the next one. Inputs are sampled into shadow registers only at the
//   frame boundary (end of the digit-3 slot), so a frame never mixes two
//   input values. All display outputs are registered (one clock latency).
//   Ports:
//     clk         in  1   system clock
//     clr         in  1   synchronous active-high reset
//     value_in    in  16  four nibbles, [3:0] = digit 0 (rightmost)
//     dp_in       in  4   decimal point request per digit, 1 = lit
//     hex_mode    in  1   1: nibbles 10..15 show A..F; 0: dash
//     blank_lz    in  1   1: blank leading zeros (digit 0 never blanked)
//     an          out 4   anodes, active-low one-hot, an[0] = digit 0
//     seg         out 7   cathodes {g,f,e,d,c,b,a}, active-low
//     dp          out 1   decimal point cathode, active-low
//     frame_tick  out 1   one-cycle pulse after the shadow registers load
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        hex_mode,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GHOST_END = CW'(BLANK_CYCLES);

  // State
  logic [CW-1:0] r_ref_cnt;
  logic [1:0]    r_digit_idx;
  shadow_t       r_shadow;

  // Output registers
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  // Combinational next-output terms
  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_ghost;
  logic [3:0]    w_nibble;
  logic [6:0]    w_dec_seg;
  logic          w_lz;
  logic [3:0]    w_an_next;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  assign w_slot_end  = (r_ref_cnt == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_digit_idx == 2'd3);
  assign w_ghost     = (r_ref_cnt < GHOST_END);

  // Select the shadowed nibble for the digit currently being scanned
  always_comb begin
    w_nibble = r_shadow.value[3:0];
    case (r_digit_idx)
      2'd0: w_nibble = r_shadow.value[3:0];
      2'd1: w_nibble = r_shadow.value[7:4];
      2'd2: w_nibble = r_shadow.value[11:8];
      2'd3: w_nibble = r_shadow.value[15:12];
      default: w_nibble = r_shadow.value[3:0];
    endcase
  end

  seg7_decode u_decode (
    .i_nibble   (w_nibble),
    .i_hex_mode (r_shadow.hex_mode),
    .o_seg      (w_dec_seg)
  );

  assign w_lz = lz_blank(r_shadow.value, r_digit_idx, r_shadow.blank_lz);

  // During the ghost window everything is dark. Outside it the anode is
  // driven even for a blanked leading zero so its decimal point can still
  // light.
  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_OFF;
    w_dp_next  = 1'b1;
    if (!w_ghost) begin
      w_an_next  = ~(4'b0001 << r_digit_idx);
      w_seg_next = w_lz ? SEG_OFF : w_dec_seg;
      w_dp_next  = ~r_shadow.dp[r_digit_idx];
    end
  end

  // Refresh counter, digit index and frame snapshot
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ref_cnt    <= '0;
      r_digit_idx  <= 2'd0;
      r_shadow     <= SHADOW_RESET;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_slot_end) begin
        r_ref_cnt   <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_ref_cnt   <= r_ref_cnt + 1'b1;
      end
      if (w_frame_end) begin
        r_shadow.value    <= value_in;
        r_shadow.dp       <= dp_in;
        r_shadow.hex_mode <= hex_mode;
        r_shadow.blank_lz <= blank_lz;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with REFRESH_DIV=8,
//   BLANK_CYCLES=2. A reference model tracks the number of clocks since
//   reset and derives slot, digit, ghost window and frame boundaries from
//   it arithmetically; every cycle the DUT pins are compared against it.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLK   = 2;
  localparam int unsigned FRAME = 4 * DIV;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned m_s;          // clocks since reset
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_hex;
  logic        m_blz;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_tick;

  function automatic logic [3:0] model_an(input int unsigned s);
    int unsigned digit;
    digit = (s / DIV) % 4;
    if ((s % DIV) < BLK) return 4'hF;
    return 4'((~(1 << digit)) & 4'hF);
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned s,
                                           input logic [15:0] v,
                                           input logic hx, input logic bl);
    int unsigned digit;
    int unsigned nib;
    digit = (s / DIV) % 4;
    if ((s % DIV) < BLK) return 7'h7F;
    nib = (int'(v) >> (4 * digit)) & 15;
    // all nibbles from this digit leftwards are zero
    if (bl && digit > 0 && ((int'(v) >> (4 * digit)) == 0)) return 7'h7F;
    if (nib > 9 && !hx) return 7'h3F;
    return seg_tab[nib];
  endfunction

  function automatic logic model_dp(input int unsigned s, input logic [3:0] d);
    int unsigned digit;
    digit = (s / DIV) % 4;
    if ((s % DIV) < BLK) return 1'b1;
    return ~d[digit];
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_s      <= 0;
      m_val    <= '0;
      m_dp     <= '0;
      m_hex    <= 1'b0;
      m_blz    <= 1'b0;
      exp_an   <= 4'hF;
      exp_seg  <= 7'h7F;
      exp_dp   <= 1'b1;
      exp_tick <= 1'b0;
    end else begin
      exp_an   <= model_an(m_s);
      exp_seg  <= model_seg(m_s, m_val, m_hex, m_blz);
      exp_dp   <= model_dp(m_s, m_dp);
      exp_tick <= ((m_s % FRAME) == FRAME - 1);
      if ((m_s % FRAME) == FRAME - 1) begin
        m_val <= value_in;
        m_dp  <= dp_in;
        m_hex <= hex_mode;
        m_blz <= blank_lz;
      end
      m_s <= m_s + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("an",   {28'd0, an},      {28'd0, exp_an});
      check("seg",  {25'd0, seg},     {25'd0, exp_seg});
      check("dp",   {31'd0, dp},      {31'd0, exp_dp});
      check("tick", {31'd0, frame_tick}, {31'd0, exp_tick});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] v, input logic [3:0] d,
                       input logic hx, input logic bl);
    value_in = v;
    dp_in    = d;
    hex_mode = hx;
    blank_lz = bl;
  endtask

  task automatic wait_tick(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    check("tick_wait", {31'd0, frame_tick}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1;
    drive(16'h0000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b1;
    run_cycles(2);
    // direct reset-state check after 3 cycles of clr
    check("rst_an",  {28'd0, an},  32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    clr = 1'b0;

    // first digit appears on the third clock after release
    run_cycles(3);
    check("first_an",  {28'd0, an},  32'hE);
    check("first_seg", {25'd0, seg}, 32'h40);

    // scan order with 1234 latched at the first boundary
    drive(16'h1234, 4'b0101, 1'b0, 1'b0);
    run_cycles(2 * FRAME);

    // change mid-frame; display holds until the next boundary
    run_cycles(FRAME / 2 + 3);
    drive(16'h9999, 4'h0, 1'b0, 1'b0);
    run_cycles(2 * FRAME);

    // leading-zero blanking
    drive(16'h0070, 4'b1000, 1'b0, 1'b1);
    run_cycles(2 * FRAME);
    drive(16'h0000, 4'h0, 1'b0, 1'b1);
    run_cycles(2 * FRAME);

    // hex vs dash
    drive(16'hABCF, 4'h0, 1'b1, 1'b0);
    run_cycles(2 * FRAME);
    drive(16'hABCF, 4'h0, 1'b0, 1'b0);
    run_cycles(2 * FRAME);

    // mid-frame clear during the digit-2 slot
    wait_tick(FRAME + 4);
    run_cycles(2 * DIV + 3);
    clr = 1'b1;
    run_cycles(1);
    clr = 1'b0;
    drive(16'h5678, 4'hF, 1'b0, 1'b0);
    run_cycles(2 * FRAME + 4);

    // randomized traffic with occasional clears
    for (int i = 0; i < 40; i++) begin
      drive(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        value_in = 16'($urandom_range(0, 255));
      run_cycles($urandom_range(1, 40));
      if ($urandom_range(0, 9) == 0) begin
        clr = 1'b1;
        run_cycles($urandom_range(1, 3));
        clr = 1'b0;
      end
    end
    run_cycles(FRAME);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
